// File: rtl/int_div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU with a pipeline stall/done handshake.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| skip the iteration phase.

package riscv_types;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_t;
endpackage

module int_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  riscv_types::alu_t alu_ctrl_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o
);
    import riscv_types::*;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] dividend;
    logic            neg_a;
    logic            neg_b;
    logic            want_rem;
    logic            div_zero;
    logic            overflow;

    // Request decode and operand conditioning
    logic            accept;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            in_zero;
    logic            in_ovf;
    logic            early;

    always_comb begin
        accept    = start_i && (alu_ctrl_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
        op_signed = (alu_ctrl_i == ALU_DIV) || (alu_ctrl_i == ALU_REM);
        op_rem    = (alu_ctrl_i == ALU_REM) || (alu_ctrl_i == ALU_REMU);
        a_neg     = op_signed && op_a_i[XLEN-1];
        b_neg     = op_signed && op_b_i[XLEN-1];
        abs_a     = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        abs_b     = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        in_zero   = (op_b_i == '0);
        in_ovf    = op_signed && (op_a_i == MIN_NEG) && (op_b_i == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = in_zero || in_ovf || (abs_a < abs_b);
`else
        early     = 1'b0;
`endif
    end

    // One restoring step: rem_sh carries the extra top bit so the trial compare is exact
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_next;

    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        ge       = (rem_sh >= {1'b0, divisor});
        rem_next = ge ? (rem_sh[XLEN-1:0] - divisor) : rem_sh[XLEN-1:0];
    end

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res;

    always_comb begin
        q_fix = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
        r_fix = neg_a ? (~rem + 1'b1) : rem;
        if (div_zero)
            res = want_rem ? dividend : '1;
        else if (overflow)
            res = want_rem ? '0 : MIN_NEG;
        else
            res = want_rem ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            dividend <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            want_rem <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            divisor  <= abs_b;
                            dividend <= op_a_i;
                            neg_a    <= a_neg;
                            neg_b    <= b_neg;
                            want_rem <= op_rem;
                            div_zero <= in_zero;
                            overflow <= in_ovf;
                            count    <= CW'(XLEN - 1);
                            busy_o   <= 1'b1;
                            // Early-out preloads quotient 0 / remainder |a| so FIXUP handles |a|<|b|
                            if (early) begin
                                state <= FIXUP;
                                quo   <= '0;
                                rem   <= abs_a;
                            end else begin
                                state <= CALC;
                                quo   <= abs_a;
                                rem   <= '0;
                            end
                        end
                    end
                    CALC: begin
                        quo   <= {quo[XLEN-2:0], ge};
                        rem   <= rem_next;
                        count <= count - 1'b1;
                        if (count == '0)
                            state <= FIXUP;
                    end
                    FIXUP: begin
                        result_o <= res;
                        done_o   <= 1'b1;
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
